// File: rtl/vga_pkg.sv
// Shared VGA constants and types: visible geometry, position widths, display modes, RGB111 colours.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int XW       = 10;
  localparam int YW       = 9;

  typedef logic [XW-1:0] pos_x_t;
  typedef logic [YW-1:0] pos_y_t;

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_HMIR   = 2'd1,
    MODE_VMIR   = 2'd2,
    MODE_ROT180 = 2'd3
  } mode_e;

  // RGB111, red in the MSB
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

endpackage

// File: rtl/vga_tile_mapper_if.sv
// Bundle between the VGA driver / frame buffer side (master) and the tile mapper (slave).
interface vga_tile_mapper_if #(
  parameter int AW = 4,
  parameter int DW = 3
);
  import vga_pkg::*;

  pos_x_t        pos_x;
  pos_y_t        pos_y;
  mode_e         mode;
  logic [AW-1:0] page_base;
  logic [DW-1:0] border_color;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic          frame_start;

  modport master (
    output pos_x, pos_y, mode, page_base, border_color, mem_data,
    input  mem_addr, pixel_out, pixel_valid, frame_start
  );

  modport slave (
    input  pos_x, pos_y, mode, page_base, border_color, mem_data,
    output mem_addr, pixel_out, pixel_valid, frame_start
  );

endinterface

// File: rtl/tile_axis_counter.sv
// One grid axis: position-in-tile counter plus saturating tile index, exported as index*STRIDE
// so the caller gets either the column (STRIDE=1) or the row base (STRIDE=COLS) without a multiplier.
module tile_axis_counter #(
  parameter int TILE   = 160,
  parameter int N      = 4,
  parameter int STRIDE = 1,
  parameter int BW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [BW-1:0] tile_base
);

  localparam int CNTW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;

  logic [CNTW-1:0] cnt_q, cnt_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [BW-1:0]   base_q, base_n;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    cnt_n  = cnt_q;
    idx_n  = idx_q;
    base_n = base_q;
    if (clear) begin
      cnt_n  = '0;
      idx_n  = '0;
      base_n = '0;
    end else if (step) begin
      if (cnt_q == CNTW'(TILE - 1)) begin
        cnt_n = '0;
        // the last tile absorbs any overrun instead of wrapping back to tile 0
        if (idx_q != IW'(N - 1)) begin
          idx_n  = idx_q + IW'(1);
          base_n = base_q + BW'(STRIDE);
        end
      end else begin
        cnt_n = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      base_q <= '0;
    end else begin
      cnt_q  <= cnt_n;
      idx_q  <= idx_n;
      base_q <= base_n;
    end
  end

  // the registers track the previous position; the caller needs the tile of the current one
  assign tile_base = base_n;

endmodule

// File: rtl/vga_tile_mapper.sv
// Maps the driver's next-pixel position onto a COLS x ROWS tile grid in the frame buffer and
// realigns the returned colour with blanking/border flags before it reaches pixelIn.
module vga_tile_mapper #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int AW       = 4,
  parameter int DW       = 3,
  parameter int READ_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  vga_tile_mapper_if.slave bus
);
  import vga_pkg::*;

  localparam int TILE_W = H_ACTIVE / COLS;
  localparam int TILE_H = V_ACTIVE / ROWS;
  localparam int STAGES = READ_LAT + 1;

  localparam logic [AW-1:0] LAST_COL      = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] LAST_IDX      = AW'(COLS * ROWS - 1);

  logic              line_start, frame_first, in_area, show, active;
  logic              line_ok_q;
  mode_e             mode_q, mode_cur;
  logic [AW-1:0]     base_q, base_cur;
  logic [AW-1:0]     col, row_base, idx;
  logic [STAGES-1:0] act_pipe, show_pipe;
  logic [DW-1:0]     pix_n;

  assign line_start  = (bus.pos_x == '0);
  assign frame_first = line_start && (bus.pos_y == '0);
  assign in_area     = (bus.pos_x < XW'(H_ACTIVE)) && (bus.pos_y < YW'(V_ACTIVE));
  // after a mid-frame reset nothing is shown until the next line start resynchronises the columns
  assign show        = line_ok_q || line_start;
  assign active      = in_area && show;

  tile_axis_counter #(
    .TILE(TILE_W), .N(COLS), .STRIDE(1), .BW(AW)
  ) u_h_axis (
    .clk(clk), .rst(rst), .clear(line_start), .step(active), .tile_base(col)
  );

  tile_axis_counter #(
    .TILE(TILE_H), .N(ROWS), .STRIDE(COLS), .BW(AW)
  ) u_v_axis (
    .clk(clk), .rst(rst), .clear(frame_first), .step(line_start), .tile_base(row_base)
  );

  // the frame's new mode and page already apply to its first pixel
  always_comb begin
    mode_cur = mode_q;
    base_cur = base_q;
    if (frame_first) begin
      mode_cur = bus.mode;
      base_cur = bus.page_base;
    end
  end

  always_comb begin
    idx = row_base + col;
    case (mode_cur)
      MODE_HMIR:   idx = row_base + (LAST_COL - col);
      MODE_VMIR:   idx = (LAST_ROW_BASE - row_base) + col;
      MODE_ROT180: idx = LAST_IDX - (row_base + col);
      default:     idx = row_base + col;
    endcase
  end

  always_comb begin
    pix_n = '0;
    if (act_pipe[STAGES-1]) begin
      pix_n = bus.mem_data;
    end else if (show_pipe[STAGES-1]) begin
      pix_n = bus.border_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr    <= '0;
      bus.pixel_out   <= '0;
      bus.pixel_valid <= 1'b0;
      bus.frame_start <= 1'b0;
      mode_q          <= MODE_LINEAR;
      base_q          <= '0;
      line_ok_q       <= 1'b0;
      act_pipe        <= '0;
      show_pipe       <= '0;
    end else begin
      bus.frame_start <= frame_first;
      if (frame_first) begin
        mode_q <= bus.mode;
        base_q <= bus.page_base;
      end
      if (line_start) begin
        line_ok_q <= 1'b1;
      end
      // page wrap-around is intentional: base + idx simply rolls over AW bits
      if (active) begin
        bus.mem_addr <= base_cur + idx;
      end
      act_pipe        <= {act_pipe[STAGES-2:0], active};
      show_pipe       <= {show_pipe[STAGES-2:0], show};
      bus.pixel_out   <= pix_n;
      bus.pixel_valid <= act_pipe[STAGES-1];
    end
  end

endmodule

// File: doc/vga_tile_mapper.md
Name: vga_tile_mapper

Overview:
Parametrised successor to the hard-wired 4x4 position-to-address decoder in the VGA top level. Maps the VGA driver's next-pixel position onto a COLS x ROWS tile grid held in the dual-port frame buffer, using incremental counters instead of comparator chains or division. Supports per-frame mirror and rotate modes and page-based double buffering. Aligns the returned RAM colour with blanking and border information before it reaches the driver's pixelIn.

Parameters:
H_ACTIVE, 640, visible pixels per line; must be divisible by COLS.
V_ACTIVE, 480, visible lines per frame; must be divisible by ROWS.
COLS, 4, tiles per row; TILE_W = H_ACTIVE/COLS.
ROWS, 4, tile rows; TILE_H = V_ACTIVE/ROWS.
AW, 4, RAM address width; COLS*ROWS <= 2**AW.
DW, 3, pixel width (RGB 111).
READ_LAT, 1, RAM read latency in clk cycles (1..3).

Ports:
clk  in  1  pixel clock (25 MHz domain)
rst  in  1  synchronous, active-high reset
pos_x  in  10  next pixel X from VGA driver
pos_y  in  9  next pixel Y from VGA driver
mode  in  2  0 linear, 1 H-mirror, 2 V-mirror, 3 rotate-180
page_base  in  AW  base address of the displayed page
border_color  in  DW  colour for positions outside the active area
mem_addr  out  AW  read address to buffer_ram_dp addr_out
mem_data  in  DW  RAM read data, valid READ_LAT cycles after mem_addr
pixel_out  out  DW  colour to the VGA driver pixelIn
pixel_valid  out  1  pixel_out belongs to the active area
frame_start  out  1  one-cycle pulse when (pos_x,pos_y) = (0,0)

Behaviour:
- Reset (rst=1 at a clk edge): mem_addr=0, pixel_out=0, pixel_valid=0, frame_start=0. All counters and pipeline flags clear. mode_q=0, base_q=0.
- Active area: pos_x < H_ACTIVE and pos_y < V_ACTIVE. Intervals are half-open, so tile c covers x in [c*TILE_W, (c+1)*TILE_W).
- Horizontal counters: when pos_x==0, clear px_cnt and col. Otherwise, while active, px_cnt increments. When px_cnt reaches TILE_W-1, it wraps to 0 and col increments. col saturates at COLS-1.
- Vertical counters: evaluated once per line, when pos_x==0. If pos_y==0, clear ln_cnt and row. Otherwise apply the same increment/wrap with TILE_H, saturating row at ROWS-1.
- Row-base accumulator: row_base = row*COLS, built by adding COLS. No multipliers and no dividers.
- Per-frame latch: when pos_x==0 and pos_y==0, latch mode_q<=mode and base_q<=page_base and pulse frame_start. Changes on mode or page_base mid-frame have no effect until the next frame.
- Index by mode_q: 0 row*COLS+col; 1 row*COLS+(COLS-1-col); 2 (ROWS-1-row)*COLS+col; 3 COLS*ROWS-1-(row*COLS+col).
- Address: mem_addr <= (base_q + idx) mod 2**AW, registered one cycle after pos. Wrap-around is silent.
- Outside the active area, mem_addr holds its last value.
- Pipeline: the active and border flags are delayed by 1+READ_LAT stages. pixel_out is registered and equals mem_data when the delayed active flag is 1, else border_color. pixel_valid is the delayed active flag.
- Total latency from pos to pixel_out is READ_LAT+2 cycles. The integrator compensates by delaying sync.
- Simultaneous events: the frame latch and the counter clear on (0,0) occur in the same cycle. The new mode applies to the first pixel of the frame.
- Reset mid-frame: pixel_valid stays 0 and pixel_out stays 0 until the first line start (pos_x==0) after reset release. Counters are correct from the next frame onward. Mode and base stay 0 until the next frame_start.

Decomposition:
- Shared package vga_pkg: H_ACTIVE, V_ACTIVE, the pos_x/pos_y widths, the mode encodings (MODE_LINEAR, MODE_HMIR, MODE_VMIR, MODE_ROT180), and the RGB111 colour constants (RED, GREEN, BLUE).
- One sub-module: tile_axis_counter (pixel-in-tile counter plus tile index with wrap and saturate). It is instantiated twice: horizontal, stepped per pixel; vertical, stepped per line.

Test Plan:
- Linear map, page_base=0, READ_LAT=1: pos (0,0) gives mem_addr 0; (160,0) gives 1; (639,479) gives 15; (159,119) gives 0 and (160,120) gives 5. pixel_out equals mem_data 3 cycles after pos.
- H-mirror latched at frame start: (0,0) gives 3; (480,240) gives 8. Switching mode to 3 mid-frame leaves the address sequence unchanged until the next (0,0), after which (0,0) gives 15.
- Page flip with AW=5: page_base=16 applied mid-frame takes effect at the next frame, where (0,0) gives 16. page_base=30 with idx 5 gives 3 (wrap).
- Blanking: pos (700,10) and (10,500) with border_color=3'b001 give pixel_valid=0 and pixel_out=001 after 3 cycles. mem_addr is unchanged.
- READ_LAT=3: the RAM model returns addr-coded data, and pixel_out aligns with its address 5 cycles after pos.
- Reset asserted at pos (320,200): the next cycle shows mem_addr=0, pixel_out=0 and pixel_valid=0. pixel_valid stays 0 until the next pos_x==0, and the full frame after that matches the golden map.
